// File: rtl/popcnt_pkg.sv
// Shared definitions for the popcount scheduler: operand encodings and the
// width/latency helpers used by the counter, the scheduler and its checker.
package popcnt_pkg;

  typedef enum logic [1:0] {
    OP_A   = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  function automatic int cnt_lat(input int vw, input int gw);
    return ($clog2(vw / (3 * gw)) / $clog2(3) + 1) + 1;
  endfunction

  function automatic int sum_w(input int vw);
    return $clog2(vw) + 1;
  endfunction

  function automatic int res_w(input int idw, input int vw);
    return idw + sum_w(vw);
  endfunction

endpackage

// File: rtl/bit_cntr.sv
// Pipelined population counter: level 0 counts groups of three granules,
// and each later level adds its children in threes.
module bit_cntr
  import popcnt_pkg::*;
#(
  parameter int VECTOR_WIDTH  = 920,
  parameter int GRANULE_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           i_en,
  input  logic [VECTOR_WIDTH-1:0]        i_vec,
  output logic [sum_w(VECTOR_WIDTH)-1:0] o_sum
);

  localparam int SUM_W = sum_w(VECTOR_WIDTH);
  localparam int LAT   = cnt_lat(VECTOR_WIDTH, GRANULE_WIDTH);
  localparam int GRP_W = 3 * GRANULE_WIDTH;
  localparam int N_GRP = (VECTOR_WIDTH + GRP_W - 1) / GRP_W;
  localparam int PAD_W = N_GRP * GRP_W;

  logic [PAD_W-1:0] vec_pad;
  logic [SUM_W-1:0] lvl_d [LAT][N_GRP];
  logic [SUM_W-1:0] lvl_q [LAT][N_GRP];

  assign vec_pad = PAD_W'(i_vec);

  // Unused slots of every level stay zero, so each level can simply sum all slots of the one below.
  always_comb begin
    for (int k = 0; k < LAT; k++) begin
      for (int j = 0; j < N_GRP; j++) begin
        lvl_d[k][j] = '0;
      end
    end
    if (i_en) begin
      for (int j = 0; j < N_GRP; j++) begin
        for (int b = 0; b < GRP_W; b++) begin
          lvl_d[0][j] = lvl_d[0][j] + SUM_W'(vec_pad[j*GRP_W+b]);
        end
      end
      for (int k = 1; k < LAT; k++) begin
        for (int c = 0; c < N_GRP; c++) begin
          lvl_d[k][c/3] = lvl_d[k][c/3] + lvl_q[k-1][c];
        end
      end
    end else begin
      lvl_d = lvl_q;
    end
  end

  // Pipeline level registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) begin
        for (int j = 0; j < N_GRP; j++) begin
          lvl_q[k][j] <= '0;
        end
      end
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign o_sum = lvl_q[LAT-1][0];

endmodule

// File: rtl/popcnt_sched_chk.sv
// Invariant checks for the scheduler's result FIFO and credit counter.
module popcnt_sched_chk #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input logic             clk,
  input logic             rstn,
  input logic             i_wr,
  input logic             i_pop,
  input logic [CNT_W-1:0] i_fcnt,
  input logic [CNT_W-1:0] i_inflight
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(i_wr && (i_fcnt == CNT_W'(FIFO_DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(i_pop && (i_fcnt == '0)));

  a_inflight_bound: assert property (@(posedge clk) disable iff (!rstn)
    i_inflight <= CNT_W'(FIFO_DEPTH));

endmodule

// File: rtl/popcnt_sched.sv
// Job scheduler around one shared pipelined popcount: issues one tagged job
// per cycle and returns {tag, sum} in order through a credit-protected FIFO.
module popcnt_sched
  import popcnt_pkg::*;
#(
  parameter int VECTOR_WIDTH  = 920,
  parameter int GRANULE_WIDTH = 6,
  parameter int ID_WIDTH      = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           i_ReqValid,
  output logic                           o_ReqReady,
  input  logic [1:0]                     i_ReqOp,
  input  logic [ID_WIDTH-1:0]            i_ReqId,
  input  logic [VECTOR_WIDTH-1:0]        i_VecA,
  input  logic [VECTOR_WIDTH-1:0]        i_VecB,
  output logic                           o_ResValid,
  input  logic                           i_ResReady,
  output logic [ID_WIDTH-1:0]            o_ResId,
  output logic [sum_w(VECTOR_WIDTH)-1:0] o_ResSum,
  output logic [$clog2(FIFO_DEPTH):0]    o_Inflight,
  output logic                           o_Idle
);

  localparam int CNT_LAT = cnt_lat(VECTOR_WIDTH, GRANULE_WIDTH);
  localparam int SUM_W   = sum_w(VECTOR_WIDTH);
  localparam int REC_W   = res_w(ID_WIDTH, VECTOR_WIDTH);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  logic                    accept, fifo_wr, fifo_pop;
  logic                    live_d, live_q;
  logic [CNT_W-1:0]        inflight_d, inflight_q;
  logic [VECTOR_WIDTH-1:0] opnd_d, opnd_q;
  logic                    s0_d, s0_q;
  logic [ID_WIDTH-1:0]     id0_d, id0_q;
  logic                    tag_vld_d [CNT_LAT];
  logic                    tag_vld_q [CNT_LAT];
  logic [ID_WIDTH-1:0]     tag_id_d [CNT_LAT];
  logic [ID_WIDTH-1:0]     tag_id_q [CNT_LAT];
  logic [SUM_W-1:0]        cnt_sum;
  logic [REC_W-1:0]        mem_d [FIFO_DEPTH];
  logic [REC_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wptr_d, wptr_q, rptr_d, rptr_q;
  logic [CNT_W-1:0]        fcnt_d, fcnt_q;
  logic [REC_W-1:0]        head;

  // Ready stays low until the first clock after reset release.
  assign live_d     = 1'b1;
  assign o_ReqReady = live_q & (inflight_q < CNT_W'(FIFO_DEPTH));
  assign accept     = i_ReqValid & o_ReqReady;
  assign o_ResValid = (fcnt_q != '0);
  assign fifo_pop   = o_ResValid & i_ResReady;
  assign fifo_wr    = tag_vld_q[CNT_LAT-1];
  assign o_Inflight = inflight_q;
  assign o_Idle     = (inflight_q == '0);

  // Issue stage: form the operand on accept, otherwise inject a zero bubble.
  always_comb begin
    opnd_d = '0;
    s0_d   = 1'b0;
    id0_d  = id0_q;
    if (accept) begin
      s0_d  = 1'b1;
      id0_d = i_ReqId;
      case (op_e'(i_ReqOp))
        OP_A:    opnd_d = i_VecA;
        OP_AND:  opnd_d = i_VecA & i_VecB;
        OP_OR:   opnd_d = i_VecA | i_VecB;
        OP_XOR:  opnd_d = i_VecA ^ i_VecB;
        default: opnd_d = i_VecA;
      endcase
    end else begin
      opnd_d = '0;
    end
  end

  // Tag pipe mirrors the counter depth so its last stage lines up with cnt_sum.
  always_comb begin
    tag_vld_d[0] = s0_q;
    tag_id_d[0]  = id0_q;
    for (int i = 1; i < CNT_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // Credit count: every job owns a FIFO slot from accept until its result is popped.
  always_comb begin
    case ({accept, fifo_pop})
      2'b10:   inflight_d = inflight_q + CNT_W'(1'b1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1'b1);
      default: inflight_d = inflight_q;
    endcase
  end

  // First-word fall-through FIFO; write and pop in one cycle both take effect.
  always_comb begin
    mem_d = mem_q;
    if (fifo_wr) begin
      mem_d[wptr_q] = {tag_id_q[CNT_LAT-1], cnt_sum};
      wptr_d        = wptr_q + PTR_W'(1'b1);
    end else begin
      wptr_d = wptr_q;
    end
    if (fifo_pop) begin
      rptr_d = rptr_q + PTR_W'(1'b1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({fifo_wr, fifo_pop})
      2'b10:   fcnt_d = fcnt_q + CNT_W'(1'b1);
      2'b01:   fcnt_d = fcnt_q - CNT_W'(1'b1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Head record is forced to zero while the FIFO is empty.
  always_comb begin
    if (o_ResValid) begin
      head = mem_q[rptr_q];
    end else begin
      head = '0;
    end
  end

  assign o_ResId  = head[REC_W-1:SUM_W];
  assign o_ResSum = head[SUM_W-1:0];

  // State registers; reset discards every in-flight job and queued result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live_q     <= 1'b0;
      inflight_q <= '0;
      opnd_q     <= '0;
      s0_q       <= 1'b0;
      id0_q      <= '0;
      for (int i = 0; i < CNT_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      live_q     <= live_d;
      inflight_q <= inflight_d;
      opnd_q     <= opnd_d;
      s0_q       <= s0_d;
      id0_q      <= id0_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  bit_cntr #(
    .VECTOR_WIDTH  (VECTOR_WIDTH),
    .GRANULE_WIDTH (GRANULE_WIDTH)
  ) u_cntr (
    .clk   (clk),
    .rstn  (rstn),
    .i_en  (1'b1),
    .i_vec (opnd_q),
    .o_sum (cnt_sum)
  );

  popcnt_sched_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk        (clk),
    .rstn       (rstn),
    .i_wr       (fifo_wr),
    .i_pop      (fifo_pop),
    .i_fcnt     (fcnt_q),
    .i_inflight (inflight_q)
  );

endmodule

// File: tb/tb_popcnt_sched.sv
// Directed bench for popcnt_sched: reset, latency, op modes, backpressure,
// sustained throughput and reset with work in flight.
module tb_popcnt_sched;

  localparam int VW  = 920;
  localparam int IDW = 16;
  localparam int SW  = 11;
  localparam int IFW = 4;
  localparam int NJ  = 128;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           i_ReqValid = 1'b0;
  logic           o_ReqReady;
  logic [1:0]     i_ReqOp = 2'b00;
  logic [IDW-1:0] i_ReqId = '0;
  logic [VW-1:0]  i_VecA = '0;
  logic [VW-1:0]  i_VecB = '0;
  logic           o_ResValid;
  logic           i_ResReady = 1'b0;
  logic [IDW-1:0] o_ResId;
  logic [SW-1:0]  o_ResSum;
  logic [IFW-1:0] o_Inflight;
  logic           o_Idle;

  int n_checks = 0;
  int n_fail   = 0;

  // job table and observed traffic
  logic [1:0]     job_op [NJ];
  logic [IDW-1:0] job_id [NJ];
  logic [VW-1:0]  job_a  [NJ];
  logic [VW-1:0]  job_b  [NJ];
  int             n_jobs_tot;
  int             next_job;
  int             cyc = 0;
  int             acc_cyc[$];
  int             pop_cyc[$];
  logic [IDW-1:0] got_id[$];
  logic [SW-1:0]  got_sum[$];

  always #5 clk = ~clk;

  popcnt_sched dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_ReqValid (i_ReqValid),
    .o_ReqReady (o_ReqReady),
    .i_ReqOp    (i_ReqOp),
    .i_ReqId    (i_ReqId),
    .i_VecA     (i_VecA),
    .i_VecB     (i_VecB),
    .o_ResValid (o_ResValid),
    .i_ResReady (i_ResReady),
    .o_ResId    (o_ResId),
    .o_ResSum   (o_ResSum),
    .o_Inflight (o_Inflight),
    .o_Idle     (o_Idle)
  );

  function automatic int ref_sum(input logic [1:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
    case (op)
      2'b00:   return $countones(a);
      2'b01:   return $countones(a & b);
      2'b10:   return $countones(a | b);
      default: return $countones(a ^ b);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_traffic(input int tot);
    n_jobs_tot = tot;
    next_job   = 0;
    acc_cyc.delete();
    pop_cyc.delete();
    got_id.delete();
    got_sum.delete();
  endtask

  // one clock of traffic: offer the next job, record accept and pop, advance
  task automatic step();
    logic acc, pop;
    if (next_job < n_jobs_tot) begin
      i_ReqValid = 1'b1;
      i_ReqOp    = job_op[next_job];
      i_ReqId    = job_id[next_job];
      i_VecA     = job_a[next_job];
      i_VecB     = job_b[next_job];
    end else begin
      i_ReqValid = 1'b0;
    end
    acc = i_ReqValid && o_ReqReady;
    pop = o_ResValid && i_ResReady;
    if (pop) begin
      got_id.push_back(o_ResId);
      got_sum.push_back(o_ResSum);
      pop_cyc.push_back(cyc);
    end
    tick();
    if (acc) begin
      acc_cyc.push_back(cyc);
      next_job++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (o_ReqReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_ReqReady); end
    n_checks++; if (o_ResValid !== 1'b0) begin n_fail++; $display("FAIL reset_resvalid: got %b want 0", o_ResValid); end
    n_checks++; if (o_Idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", o_Idle); end
    n_checks++; if (o_Inflight !== 4'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", o_Inflight); end
    n_checks++; if ({o_ResId, o_ResSum} !== '0) begin n_fail++; $display("FAIL reset_result: got %h/%0d want 0/0", o_ResId, o_ResSum); end
    rstn = 1'b1;
    n_checks++; if (o_ReqReady !== 1'b0) begin n_fail++; $display("FAIL release_ready_early: got %b want 0", o_ReqReady); end
    tick();
    n_checks++; if (o_ReqReady !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", o_ReqReady); end
  endtask

  task automatic test_single();
    int rise = 0;
    clear_traffic(1);
    job_op[0] = 2'b01; job_id[0] = 16'h0001;
    job_a[0] = '1;     job_b[0] = '1;
    i_ResReady = 1'b0;
    step();
    n_checks++; if (acc_cyc.size() !== 1) begin n_fail++; $display("FAIL single_accept: got %0d accepts want 1", acc_cyc.size()); end
    // cycle count includes the cycle that begins at the accept edge
    for (int i = 0; i < 15 && rise == 0; i++) begin
      step();
      if (o_ResValid === 1'b1) rise = cyc - acc_cyc[0] + 1;
    end
    n_checks++; if (rise !== 7) begin n_fail++; $display("FAIL single_latency: got %0d want 7", rise); end
    n_checks++; if (o_ResSum !== 11'd920) begin n_fail++; $display("FAIL single_sum: got %0d want 920", o_ResSum); end
    n_checks++; if (o_ResId !== 16'h0001) begin n_fail++; $display("FAIL single_id: got %h want 0001", o_ResId); end
    tick();
    n_checks++; if (o_ResSum !== 11'd920) begin n_fail++; $display("FAIL single_hold: got %0d want 920", o_ResSum); end
    i_ResReady = 1'b1;
    step();
    i_ResReady = 1'b0;
    n_checks++; if (o_ResValid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", o_ResValid); end
    n_checks++; if (o_Idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b want 1", o_Idle); end
  endtask

  task automatic test_ops();
    int exp_sum [4] = '{4, 2, 6, 4};
    clear_traffic(4);
    for (int k = 0; k < 4; k++) begin
      job_op[k] = 2'(k);
      job_id[k] = 16'(k + 1);
      job_a[k] = '0; job_a[k][7:0] = 8'hF0;
      job_b[k] = '0; job_b[k][7:0] = 8'h3C;
    end
    i_ResReady = 1'b1;
    for (int i = 0; i < 40 && got_id.size() < 4; i++) step();
    n_checks++; if (got_id.size() !== 4) begin n_fail++; $display("FAIL ops_count: got %0d want 4", got_id.size()); end
    for (int k = 0; k < 4 && k < got_id.size(); k++) begin
      n_checks++; if (got_id[k] !== 16'(k + 1)) begin n_fail++; $display("FAIL ops_id[%0d]: got %0d want %0d", k, got_id[k], k + 1); end
      n_checks++; if (got_sum[k] !== 11'(exp_sum[k])) begin n_fail++; $display("FAIL ops_sum[%0d]: got %0d want %0d", k, got_sum[k], exp_sum[k]); end
    end
  endtask

  task automatic test_backpressure();
    clear_traffic(12);
    for (int k = 0; k < 12; k++) begin
      job_op[k] = 2'(k % 4);
      job_id[k] = 16'h0100 + 16'(k);
      job_a[k] = '0;
      for (int b = 0; b <= k; b++) job_a[k][b] = 1'b1;
      job_b[k] = '1;
    end
    i_ResReady = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_checks++; if (acc_cyc.size() !== 8) begin n_fail++; $display("FAIL bp_accepted: got %0d want 8", acc_cyc.size()); end
    n_checks++; if (o_ReqReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", o_ReqReady); end
    n_checks++; if (o_Inflight !== 4'd8) begin n_fail++; $display("FAIL bp_inflight: got %0d want 8", o_Inflight); end
    i_ResReady = 1'b1;
    for (int i = 0; i < 80 && got_id.size() < 12; i++) step();
    n_checks++; if (got_id.size() !== 12) begin n_fail++; $display("FAIL bp_count: got %0d want 12", got_id.size()); end
    for (int k = 0; k < 12 && k < got_id.size(); k++) begin
      n_checks++; if (got_id[k] !== job_id[k]) begin n_fail++; $display("FAIL bp_id[%0d]: got %h want %h", k, got_id[k], job_id[k]); end
      n_checks++; if (got_sum[k] !== 11'(ref_sum(job_op[k], job_a[k], job_b[k]))) begin
        n_fail++; $display("FAIL bp_sum[%0d]: got %0d want %0d", k, got_sum[k], ref_sum(job_op[k], job_a[k], job_b[k])); end
    end
    n_checks++; if (o_Idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %b want 1", o_Idle); end
  endtask

  task automatic test_back_to_back();
    logic [927:0] tmp;
    int errs = 0;
    clear_traffic(100);
    for (int k = 0; k < 100; k++) begin
      job_op[k] = 2'($urandom_range(0, 3));
      job_id[k] = 16'h2000 + 16'(k);
      for (int w = 0; w < 29; w++) tmp[w*32 +: 32] = $urandom;
      job_a[k] = tmp[VW-1:0];
      for (int w = 0; w < 29; w++) tmp[w*32 +: 32] = $urandom;
      job_b[k] = tmp[VW-1:0];
    end
    i_ResReady = 1'b1;
    for (int i = 0; i < 300 && got_id.size() < 100; i++) step();
    n_checks++; if (acc_cyc.size() !== 100) begin n_fail++; $display("FAIL tput_accepts: got %0d want 100", acc_cyc.size()); end
    n_checks++; if (got_id.size() !== 100) begin n_fail++; $display("FAIL tput_results: got %0d want 100", got_id.size()); end
    if (acc_cyc.size() == 100 && got_id.size() == 100) begin
      n_checks++; if (acc_cyc[99] - acc_cyc[0] !== 99) begin n_fail++; $display("FAIL tput_accept_span: got %0d want 99", acc_cyc[99] - acc_cyc[0]); end
      n_checks++; if (pop_cyc[99] - pop_cyc[0] !== 99) begin n_fail++; $display("FAIL tput_result_span: got %0d want 99", pop_cyc[99] - pop_cyc[0]); end
      for (int k = 0; k < 100; k++) begin
        if (got_id[k] !== job_id[k] || got_sum[k] !== 11'(ref_sum(job_op[k], job_a[k], job_b[k]))) begin
          if (errs == 0) $display("FAIL tput_data[%0d]: got %h/%0d want %h/%0d", k, got_id[k], got_sum[k], job_id[k], ref_sum(job_op[k], job_a[k], job_b[k]));
          errs++;
        end
      end
      n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL tput_data_total: got %0d bad results want 0", errs); end
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    clear_traffic(5);
    for (int k = 0; k < 5; k++) begin
      job_op[k] = 2'b00; job_id[k] = 16'h3000 + 16'(k);
      job_a[k] = '1;     job_b[k] = '0;
    end
    i_ResReady = 1'b0;
    // accepts on the first five edges, then two results land in the FIFO
    for (int i = 0; i < 8; i++) step();
    n_checks++; if (o_Inflight !== 4'd5) begin n_fail++; $display("FAIL mid_inflight_pre: got %0d want 5", o_Inflight); end
    n_checks++; if (o_ResValid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_pre: got %b want 1", o_ResValid); end
    rstn = 1'b0;
    #1;
    n_checks++; if (o_ResValid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_reset: got %b want 0", o_ResValid); end
    n_checks++; if (o_Inflight !== 4'd0) begin n_fail++; $display("FAIL mid_inflight_reset: got %0d want 0", o_Inflight); end
    tick(); tick();
    rstn = 1'b1;
    i_ResReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_ResValid !== 1'b0) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL mid_stale: got %0d valid cycles want 0", stale); end
    n_checks++; if (o_Inflight !== 4'd0) begin n_fail++; $display("FAIL mid_inflight_post: got %0d want 0", o_Inflight); end
    n_checks++; if (o_Idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle_post: got %b want 1", o_Idle); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    i_ReqValid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
